// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 2-flop input sync, mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit before stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 Clk,
  input  logic                 RST,
  input  logic                 Serial_In,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic                 Frame_Err,
`ifdef UART_RX_PARITY_EN
  output logic                 Parity_Err,
`endif
  output logic                 RX_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BAUD_MID =
    CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] BAUD_END =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic [2:0]           state;
  logic                 sync1;
  logic                 rx_s;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 baud_end;
  logic                 baud_mid;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  assign baud_end = (baud_cnt == BAUD_END);
  assign baud_mid = (baud_cnt == BAUD_MID);
  assign RX_Busy  = (state != IDLE);

  // sync flops reset high so reset never looks like a start bit
  always_ff @(posedge Clk) begin
    if (RST) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= Serial_In;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_Err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      Data_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_Err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s)
            state <= START;
        end
        START: begin
          if (baud_mid) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            // LSB first: shift in at the top
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            par_bad  <= rx_s ^ (^shreg);
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (rx_s) begin
              Data_Out   <= shreg;
              Data_Valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              Parity_Err <= par_bad;
`endif
              state      <= IDLE;
            end else begin
              Frame_Err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        BREAK: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_s)
            state <= IDLE;
        end
        default: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames, scoreboard queue checked by a monitor.
// Build with UART_RX_PARITY_EN to add the parity frames.
module tb_uart_rx;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LAT =
    2 + (CPB - 1) / 2 + (NBITS - 1) * CPB + 2;

  typedef struct {
    bit         err;
    logic [7:0] data;
    bit         perr;
  } exp_t;

  logic       Clk = 1'b0;
  logic       RST = 1'b1;
  logic       Serial_In = 1'b1;
  logic [7:0] Data_Out;
  logic       Data_Valid;
  logic       Frame_Err;
  logic       RX_Busy;
`ifdef UART_RX_PARITY_EN
  logic       Parity_Err;
  bit         par_flip = 1'b0;
`endif

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   vcyc[$];

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8)
  ) dut (
    .Clk(Clk),
    .RST(RST),
    .Serial_In(Serial_In),
    .Data_Out(Data_Out),
    .Data_Valid(Data_Valid),
    .Frame_Err(Frame_Err),
`ifdef UART_RX_PARITY_EN
    .Parity_Err(Parity_Err),
`endif
    .RX_Busy(RX_Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_rng(string nm, int act,
                         int lo, int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  task automatic push(bit err, logic [7:0] d, bit perr);
    exp_t e;
    e.err  = err;
    e.data = d;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  // monitor: every output pulse must match the queue head
  always @(negedge Clk) begin
    exp_t e;
    if (Data_Valid || Frame_Err) begin
      chk("valid_err_excl",
          int'(Data_Valid & Frame_Err), 0);
      chk("pulse_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pulse_kind", int'(Frame_Err), int'(e.err));
        chk("data_out", int'(Data_Out), int'(e.data));
`ifdef UART_RX_PARITY_EN
        chk("parity_err", int'(Parity_Err), int'(e.perr));
`endif
      end
      if (Data_Valid)
        vcyc.push_back(cyc);
    end
  end

  task automatic idle(int n);
    Serial_In = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_bit(logic b);
    Serial_In = b;
    repeat (CPB) @(negedge Clk);
  endtask

  task automatic send_frame(logic [7:0] d, logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++)
      send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  task automatic wait_drain(int maxc);
    int k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(negedge Clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_data"}, int'(Data_Out), 0);
    chk({nm, "_valid"}, int'(Data_Valid), 0);
    chk({nm, "_ferr"}, int'(Frame_Err), 0);
    chk({nm, "_busy"}, int'(RX_Busy), 0);
`ifdef UART_RX_PARITY_EN
    chk({nm, "_perr"}, int'(Parity_Err), 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int         t0;
    int         busy;
    logic [7:0] d81;

    RST = 1'b1;
    Serial_In = 1'b1;
    repeat (3) @(negedge Clk);
    chk_zero("reset");
    RST = 1'b0;
    idle(5);

    // single frame, latency and return to idle
    vcyc.delete();
    push(1'b0, 8'hDB, 1'b0);
    t0 = cyc;
    send_frame(8'hDB, 1'b1);
    wait_drain(40);
    idle(4);
    chk("t1_busy_low", int'(RX_Busy), 0);
    chk("t1_pulses", vcyc.size(), 1);
    if (vcyc.size() == 1)
      chk_rng("t1_latency", vcyc[0] - t0, LAT - 1, LAT + 1);

    // back-to-back frames, no idle gap
    vcyc.delete();
    push(1'b0, 8'h55, 1'b0);
    push(1'b0, 8'hA3, 1'b0);
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    wait_drain(40);
    idle(4);
    chk("t2_pulses", vcyc.size(), 2);
    if (vcyc.size() == 2)
      chk("t2_gap", vcyc[1] - vcyc[0], NBITS * CPB);
    chk("t2_data_hold", int'(Data_Out), 'hA3);

    // 2-cycle glitch is rejected from START
    vcyc.delete();
    busy = 0;
    Serial_In = 1'b0;
    repeat (2) @(negedge Clk);
    Serial_In = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (RX_Busy)
        busy++;
    end
    chk_rng("t3_busy_cycles", busy, 1, 4);
    chk("t3_no_valid", vcyc.size(), 0);
    chk("t3_busy_low", int'(RX_Busy), 0);

    // framing error, then line held low
    push(1'b1, 8'hA3, 1'b0);
    send_frame(8'h3C, 1'b0);
    Serial_In = 1'b0;
    repeat (30) @(negedge Clk);
    chk("t4_err_seen", exp_q.size(), 0);
    chk("t4_busy_break", int'(RX_Busy), 1);
    chk("t4_data_hold", int'(Data_Out), 'hA3);
    Serial_In = 1'b1;
    repeat (5) @(negedge Clk);
    chk("t4_busy_low", int'(RX_Busy), 0);
    idle(10);

    // reset in the middle of bit 4
    vcyc.delete();
    d81 = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(d81[i]);
    Serial_In = d81[4];
    repeat (CPB / 2) @(negedge Clk);
    RST = 1'b1;
    @(negedge Clk);
    RST = 1'b0;
    Serial_In = 1'b1;
    chk_zero("t5_reset");
    idle(100);
    chk("t5_no_pulse", vcyc.size(), 0);
    push(1'b0, 8'h7E, 1'b0);
    send_frame(8'h7E, 1'b1);
    wait_drain(40);
    idle(4);
    chk("t5_after", vcyc.size(), 1);

`ifdef UART_RX_PARITY_EN
    // good then bad parity on 0x07
    par_flip = 1'b0;
    push(1'b0, 8'h07, 1'b0);
    send_frame(8'h07, 1'b1);
    wait_drain(40);
    idle(4);
    par_flip = 1'b1;
    push(1'b0, 8'h07, 1'b1);
    send_frame(8'h07, 1'b1);
    wait_drain(40);
    idle(4);
    par_flip = 1'b0;
    chk("t6_data", int'(Data_Out), 'h07);
`endif

    idle(10);
    chk("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART serial receiver that sits directly downstream of the UART transmitter and consumes its Serial_Out line.
- Recovers 8N1 frames: idle-high line, one start bit (0), DATA_BITS data bits LSB first, and one stop bit (1).
- Presents each received byte on a parallel bus with a one-cycle valid strobe, and flags framing errors.
- Baud timing matches the transmitter: a fixed number of Clk cycles per bit.

Parameters:
- CLKS_PER_BIT, 16: Clk cycles per serial bit. Must be >= 4 and must equal the transmitter's value.
- DATA_BITS, 8: data bits per frame. Legal range is 5 to 8.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous reset, active-high.
- Serial_In  input  1  asynchronous serial line; idles at 1.
- Data_Out  output  DATA_BITS  last correctly received byte.
- Data_Valid  output  1  one-cycle pulse when Data_Out is updated.
- Frame_Err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- RX_Busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (RST=1 at a rising Clk edge): state=IDLE, bit counter=0, baud counter=0, Data_Out=0, Data_Valid=0, Frame_Err=0, RX_Busy=0.
  - Synchronizer flops are set to 1, so no false start follows reset.
  - Reset takes priority over everything, including mid-frame. The partial frame is discarded with no Valid or Err pulse.
- Input synchronizer: Serial_In passes through 2 flops to give rx_s. All decisions use rx_s, which adds 2 cycles of input latency.
- States: IDLE, START, DATA, STOP, BREAK (plus PARITY, see Optional Feature).
- IDLE:
  - rx_s==0 -> START, baud counter cleared to 0.
  - Otherwise stay in IDLE.
- START:
  - Baud counter increments every cycle.
  - When the counter reaches (CLKS_PER_BIT-1)/2 (integer division), rx_s is sampled at mid-start-bit.
  - Sample 0 -> DATA, baud counter=0, bit counter=0.
  - Sample 1 -> false start (glitch): back to IDLE, no outputs asserted.
- DATA:
  - When the baud counter reaches CLKS_PER_BIT-1, rx_s is sampled and shifted into the shift register from the MSB side, so the first bit received lands at bit 0 (LSB-first).
  - Baud counter returns to 0 and the bit counter increments.
  - After DATA_BITS samples -> STOP.
- STOP:
  - Sample taken at baud counter = CLKS_PER_BIT-1.
  - rx_s==1: the cycle after the sample, Data_Out <= shift register and Data_Valid=1 for exactly one cycle. Next state IDLE.
  - rx_s==0: the cycle after the sample, Frame_Err=1 for one cycle and Data_Out is unchanged. Next state BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. This prevents a held-low line from being read as repeated frames.
- Leaving STOP at mid-stop-bit leaves half a bit of margin, so back-to-back frames with no idle gap are received without loss.
- Data_Out holds its value until the next valid frame completes.
- Data_Valid and Frame_Err are never high in the same cycle.
- End-to-end latency: Data_Valid rises 2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS+1)*CLKS_PER_BIT + 2 cycles after the start-bit falling edge on Serial_In, ±1 cycle for edge alignment.
- Counters are sized to $clog2(CLKS_PER_BIT) bits and $clog2(DATA_BITS+1) bits. Neither counter wraps; both are explicitly cleared on every state change.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit is expected between the last data bit and the stop bit. DATA -> PARITY -> STOP.
  - PARITY samples at CLKS_PER_BIT-1 and compares against the XOR of the data bits.
  - An extra output port Parity_Err (1 bit, reset 0) pulses for one cycle alongside Data_Valid when parity mismatches. Data_Out is still updated.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no Parity_Err port; plain 8N1.

Test Plan (CLKS_PER_BIT=8, DATA_BITS=8 unless stated):
1. Drive frame 0xDB (LSB first: 1,1,0,1,1,0,1,1), stop=1 -> one Data_Valid pulse, Data_Out=8'hDB, Frame_Err never asserted, RX_Busy low after the pulse.
2. Back-to-back frames 0x55 then 0xA3 with no idle gap -> two Data_Valid pulses, 80 cycles apart, Data_Out=8'h55 then 8'hA3.
3. 2-cycle low glitch on an idle line -> state returns to IDLE from START, no Data_Valid and no Frame_Err, RX_Busy high for at most 4 cycles.
4. Frame 0x3C with stop bit forced to 0, then line held low for 30 cycles -> Frame_Err pulses once, Data_Out keeps its previous value, RX_Busy stays high until the line returns to 1.
5. Assert RST for 1 cycle in the middle of bit 4 of frame 0x81 -> all outputs 0 the next cycle, no pulse for the aborted frame. A following clean 0x7E is received correctly.
6. With UART_RX_PARITY_EN: frame 0x07 with parity bit 1 -> Data_Valid, Parity_Err=0. Same frame with parity bit 0 -> Data_Valid and Parity_Err=1, Data_Out=8'h07.
